sync_fifo: RTL and testbench

- Single-clock synchronous FIFO with registered read data, a full/empty status pair, an occupancy count and almost-full/almost-empty thresholds.
- Used as a generic rate-decoupling buffer between a producer and a consumer in the same clock domain.
- The bench drives it through the fifo_ifc interface bundle, whose signals map one-to-one onto the ports below.

---
 rtl/sync_fifo_if.sv | 38 +++
 rtl/sync_fifo.sv | 93 +++++++++
 tb/tb_sync_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// fifo_ifc: handshake/data bundle between a producer/consumer and sync_fifo.
// The overflow/underflow pair exists only when SYNC_FIFO_ERR_EN is defined.
interface fifo_ifc #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                     wr_en;
    logic [DATA_W-1:0]        din;
    logic                     rd_en;
    logic [DATA_W-1:0]        dout;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
`ifdef SYNC_FIFO_ERR_EN
    logic                     overflow;
    logic                     underflow;
`endif

    // Producer/consumer side
    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
        , input overflow, underflow
`endif
    );

    // FIFO side
    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and
// almost-full/almost-empty thresholds. Define SYNC_FIFO_ERR_EN to add sticky
// overflow/underflow flags; by default rejected accesses are silently dropped.
module sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic      clk,
    input  logic      rst,
    fifo_ifc.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_dout;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A full FIFO still takes a write when a read frees a slot on the same edge
    assign w_rd_acc = bus.rd_en && !w_empty;
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

    // Storage array: written on accepted writes only, never cleared
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

    assign bus.dout         = r_dout;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus for sync_fifo with a queue scoreboard that
// predicts read data, occupancy and status flags.
module tb_sync_fifo;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_ifc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ifc ();

    sync_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] m_dout;
    logic              m_ovf;
    logic              m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = sb_q.size();
        chk({tag, ".count"}, 32'(ifc.count), 32'(n));
        chk({tag, ".empty"}, 32'(ifc.empty), 32'(n == 0));
        chk({tag, ".full"},  32'(ifc.full),  32'(n == DEPTH));
        chk({tag, ".af"},    32'(ifc.almost_full),  32'(n >= AF_LEVEL));
        chk({tag, ".ae"},    32'(ifc.almost_empty), 32'(n <= AE_LEVEL));
        chk({tag, ".dout"},  32'(ifc.dout),  32'(m_dout));
`ifdef SYNC_FIFO_ERR_EN
        chk({tag, ".ovf"},   32'(ifc.overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(ifc.underflow), 32'(m_unf));
`endif
    endtask

    // One clock with the given request; scoreboard updated, then outputs checked
    task automatic step(input string tag, input logic wr, input logic [DATA_W-1:0] d, input logic rd);
        logic rd_acc, wr_acc;
        ifc.wr_en = wr;
        ifc.din   = d;
        ifc.rd_en = rd;
        rd_acc = rd && (sb_q.size() > 0);
        wr_acc = wr && ((sb_q.size() < DEPTH) || rd_acc);
        if (wr && !wr_acc) m_ovf = 1'b1;
        if (rd && sb_q.size() == 0) m_unf = 1'b1;
        if (rd_acc) m_dout = sb_q.pop_front();
        if (wr_acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
        ifc.wr_en = 1'b0;
        ifc.rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        // Reset with both requests active
        ifc.wr_en = 1'b1;
        ifc.rd_en = 1'b1;
        ifc.din   = 8'h99;
        do_reset(2);
        ifc.wr_en = 1'b0;
        ifc.rd_en = 1'b0;
        check_state("reset");

        // Fill, overflow attempt, drain, underflow attempt
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
        step("wr_full", 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);
        step("rd_empty", 1'b0, 8'h00, 1'b1);
        chk("dout_hold", 32'(ifc.dout), 32'h10);

        // Fill/drain rounds across pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) step("round_fill", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
            for (int i = 0; i < DEPTH; i++) step("round_drain", 1'b0, 8'h00, 1'b1);
        end

        // Alternating write/read
        for (int i = 0; i < 10; i++) begin
            step("alt_wr", 1'b1, 8'(8'h55 + 8'(i) * 8'h11), 1'b0);
            step("alt_rd", 1'b0, 8'h00, 1'b1);
            chk("alt_data", 32'(ifc.dout), 32'(8'(8'h55 + 8'(i) * 8'h11)));
        end

        // Simultaneous access when empty, then when full
        step("sim_empty", 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) step("sim_fill", 1'b1, 8'(8'hC0 + 8'(i)), 1'b0);
        step("sim_full", 1'b1, 8'hE7, 1'b1);
        chk("sim_full_oldest", 32'(ifc.dout), 32'h3C);
        for (int i = 0; i < DEPTH; i++) step("sim_drain", 1'b0, 8'h00, 1'b1);
        chk("sim_full_appended", 32'(ifc.dout), 32'hE7);

        // Reset with data stored
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h20 + 8'(i)), 1'b0);
        do_reset(1);
        check_state("mid_rst");
        step("post_wr", 1'b1, 8'h77, 1'b0);
        step("post_rd", 1'b0, 8'h00, 1'b1);
        chk("post_rst_data", 32'(ifc.dout), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
